// File: rtl/sva_stim_pkg.sv
// Shared types and delay-window normalisation for the assertion stimulus driver and its checkers.
// Pure declarations: no logic, no latency, no flow control.
package sva_stim_pkg;

    localparam int unsigned DLY_MAX_W = 16;

    typedef logic [DLY_MAX_W-1:0] dly_t;

    typedef enum logic [2:0] {
        IDLE,
        ANTE,
        WAIT,
        RESOLVE,
        GAP,
        FIN
    } drv_state_t;

    typedef enum logic [1:0] {
        NONE,
        SUCC,
        FAIL
    } exp_verdict_t;

    // A zero window start would overlap the antecedent cycle, so it is pulled up to 1.
    function automatic dly_t norm_min(dly_t raw);
        return (raw == '0) ? dly_t'(1) : raw;
    endfunction

    function automatic dly_t norm_max(dly_t min_n, dly_t raw);
        return (raw < min_n) ? min_n : raw;
    endfunction

endpackage

// File: rtl/sva_seq_driver_if.sv
// Control, config and stimulus bundle between a run controller and the sequence driver.
// Level/pulse signals only; no handshake, the driver never stalls its controller.
interface sva_seq_driver_if #(
    parameter int CNT_WIDTH = 16,
    parameter int DLY_WIDTH = 4
);

    logic                 start;
    logic                 stop;
    logic [CNT_WIDTH-1:0] num_txn;
    logic [DLY_WIDTH-1:0] min_delay;
    logic [DLY_WIDTH-1:0] max_delay;
    logic [7:0]           fail_period;

    logic                 a;
    logic                 b;
    logic                 exp_succ;
    logic                 exp_fail;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] txn_idx;

    modport master (
        output start, stop, num_txn, min_delay, max_delay, fail_period,
        input  a, b, exp_succ, exp_fail, busy, done, txn_idx
    );

    modport slave (
        input  start, stop, num_txn, min_delay, max_delay, fail_period,
        output a, b, exp_succ, exp_fail, busy, done, txn_idx
    );

endinterface

// File: rtl/sva_delay_sel.sv
// Per-transaction delay and violation selection: rotating window offset plus fail-period down-counter.
// Outputs come straight from registers loaded at run start and stepped once per transaction.
module sva_delay_sel
    import sva_stim_pkg::*;
#(
    parameter int DLY_WIDTH = 4
) (
    input  logic                 gclk,
    input  logic                 grst,
    input  logic                 load,
    input  logic                 advance,
    input  logic [DLY_WIDTH-1:0] min_delay,
    input  logic [DLY_WIDTH-1:0] max_delay,
    input  logic [7:0]           fail_period,
    output logic [DLY_WIDTH-1:0] dly,
    output logic [DLY_WIDTH-1:0] win_max,
    output logic                 is_fail
);

    logic [DLY_WIDTH-1:0] min_n, max_n;
    logic [DLY_WIDTH-1:0] min_q, max_q, span_q, off;
    logic [7:0]           period_q, fcnt;

    assign min_n = DLY_WIDTH'(norm_min(dly_t'(min_delay)));
    assign max_n = DLY_WIDTH'(norm_max(dly_t'(min_n), dly_t'(max_delay)));

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            min_q  <= DLY_WIDTH'(1);
            max_q  <= DLY_WIDTH'(1);
            span_q <= '0;
            off    <= '0;
        end else if (load) begin
            min_q  <= min_n;
            max_q  <= max_n;
            span_q <= max_n - min_n;
            off    <= '0;
        end else if (advance) begin
            off <= (off == span_q) ? '0 : off + DLY_WIDTH'(1);
        end
    end

    // A count of 1 marks the current transaction as the violation; it then restarts the period.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            period_q <= '0;
            fcnt     <= '0;
        end else if (load) begin
            period_q <= fail_period;
            fcnt     <= fail_period;
        end else if (advance && (period_q != '0)) begin
            fcnt <= (fcnt == 8'd1) ? period_q : fcnt - 8'd1;
        end
    end

    assign dly     = min_q + off;
    assign win_max = max_q;
    assign is_fail = (period_q != '0) && (fcnt == 8'd1);

endmodule

// File: rtl/sva_seq_driver.sv
// Generates a |-> ##[min:max] b transactions with optional violations and aligned expected-verdict pulses.
// Outputs registered from next state (first a one cycle after start); stop aborts on the next edge.
module sva_seq_driver
    import sva_stim_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int DLY_WIDTH = 4
) (
    input  logic            gclk,
    input  logic            grst,
    sva_seq_driver_if.slave bus
);

    drv_state_t           state, state_nx;
    exp_verdict_t         verdict_nx;
    logic [CNT_WIDTH-1:0] num_q;
    logic [DLY_WIDTH-1:0] el, el_nx;
    logic [DLY_WIDTH-1:0] dly, win_max, target;
    logic                 is_fail;
    logic                 start_acc;
    logic                 last_txn;

    assign start_acc = (state == IDLE) && bus.start && !bus.stop;
    assign el_nx     = el + DLY_WIDTH'(1);
    assign target    = is_fail ? win_max : dly;
    assign last_txn  = (bus.txn_idx + CNT_WIDTH'(1)) == num_q;

    sva_delay_sel #(
        .DLY_WIDTH (DLY_WIDTH)
    ) u_delay_sel (
        .gclk        (gclk),
        .grst        (grst),
        .load        (start_acc),
        .advance     (state == GAP),
        .min_delay   (bus.min_delay),
        .max_delay   (bus.max_delay),
        .fail_period (bus.fail_period),
        .dly         (dly),
        .win_max     (win_max),
        .is_fail     (is_fail)
    );

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // el counts cycles since the antecedent; a delay of 1 goes straight from ANTE to RESOLVE.
    always_comb begin
        state_nx   = state;
        verdict_nx = NONE;
        case (state)
            IDLE:      if (start_acc) state_nx = (bus.num_txn == '0) ? FIN : ANTE;
            ANTE,
            WAIT:      state_nx = (el_nx >= target) ? RESOLVE : WAIT;
            RESOLVE:   state_nx = GAP;
            GAP:       state_nx = last_txn ? FIN : ANTE;
            FIN:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (bus.stop) begin
            state_nx = IDLE;
        end
        if (state_nx == RESOLVE) begin
            verdict_nx = is_fail ? FAIL : SUCC;
        end
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            bus.a        <= 1'b0;
            bus.b        <= 1'b0;
            bus.exp_succ <= 1'b0;
            bus.exp_fail <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.txn_idx  <= '0;
            num_q        <= '0;
            el           <= '0;
        end else begin
            bus.a        <= (state_nx == ANTE);
            bus.b        <= (verdict_nx == SUCC);
            bus.exp_succ <= (verdict_nx == SUCC);
            bus.exp_fail <= (verdict_nx == FAIL);
            bus.busy     <= (state_nx == ANTE) || (state_nx == WAIT) ||
                            (state_nx == RESOLVE) || (state_nx == GAP);
            bus.done     <= (state_nx == FIN);
            el           <= (state_nx == WAIT) ? el_nx : '0;
            if (start_acc) begin
                num_q       <= bus.num_txn;
                bus.txn_idx <= '0;
            end else if (state == GAP) begin
                bus.txn_idx <= bus.txn_idx + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_sva_seq_driver.sv
// Directed bench for sva_seq_driver: per-cycle output masks hand-derived from the transaction timing.
module tb_sva_seq_driver;

    logic gclk = 1'b0;
    logic grst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    sva_seq_driver_if #(.CNT_WIDTH(16), .DLY_WIDTH(4)) bus();

    sva_seq_driver #(.CNT_WIDTH(16), .DLY_WIDTH(4)) dut (
        .gclk (gclk),
        .grst (grst),
        .bus  (bus)
    );

    always #5 gclk = ~gclk;

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input int k, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {bus.a, bus.b, bus.exp_succ, bus.exp_fail, bus.busy, bus.done};
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: {a,b,succ,fail,busy,done} got %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_idx(input string tag, input int k, input logic [15:0] exp);
        n_chk++;
        assert (bus.txn_idx === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: txn_idx got %0d expected %0d", tag, k, bus.txn_idx, exp);
        end
    endtask

    // Bit k of each mask is the expected value in the k-th cycle after the sampling edge.
    task automatic check_run(input string tag, input int ncyc,
                             input logic [63:0] am, input logic [63:0] bm,
                             input logic [63:0] sm, input logic [63:0] fm,
                             input logic [63:0] ym, input logic [63:0] dm,
                             input int idx_end);
        for (int k = 0; k < ncyc; k++) begin
            chk_vec(tag, k, {am[k], bm[k], sm[k], fm[k], ym[k], dm[k]});
            if (k == 0 && idx_end >= 0) chk_idx(tag, k, 16'd0);
            if (k == ncyc - 1 && idx_end >= 0) chk_idx(tag, k, 16'(idx_end));
            tick();
        end
    endtask

    // Config is scrambled right after the start pulse; the run must use the captured values.
    task automatic start_run(input logic [15:0] n, input logic [3:0] mn,
                             input logic [3:0] mx, input logic [7:0] fp);
        bus.num_txn     = n;
        bus.min_delay   = mn;
        bus.max_delay   = mx;
        bus.fail_period = fp;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.num_txn     = 16'd5;
        bus.min_delay   = 4'd7;
        bus.max_delay   = 4'd15;
        bus.fail_period = 8'd1;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.num_txn     = '0;
        bus.min_delay   = '0;
        bus.max_delay   = '0;
        bus.fail_period = '0;
        tick();
        tick();
        chk_vec("reset", 0, 6'b000000);
        chk_idx("reset", 0, 16'd0);
        grst = 1'b0;
        check_run("idle", 3, 0, 0, 0, 0, 0, 0, 0);

        start_run(16'd3, 4'd2, 4'd2, 8'd0);
        check_run("basic", 14, 'h111, 'h444, 'h444, 0, 'hFFF, 'h1000, 3);

        start_run(16'd4, 4'd1, 4'd3, 8'd0);
        check_run("rotate", 17, 'h1089, 'h2422, 'h2422, 0, 'h7FFF, 'h8000, 4);

        start_run(16'd4, 4'd1, 4'd3, 8'd2);
        check_run("inject", 20, 'h2109, 'h802, 'h802, 'h10040, 'h3FFFF, 'h40000, 4);

        start_run(16'd2, 4'd2, 4'd2, 8'd1);
        check_run("fail_every", 10, 'h11, 0, 0, 'h44, 'hFF, 'h100, 2);

        start_run(16'd1, 4'd0, 4'd0, 8'd0);
        check_run("norm", 5, 'h1, 'h2, 'h2, 0, 'h7, 'h8, 1);

        start_run(16'd0, 4'd0, 4'd0, 8'd0);
        bus.start = 1'b1;
        check_run("zero_txn", 1, 0, 0, 0, 0, 0, 'h1, 0);
        bus.start = 1'b0;
        check_run("start_at_done", 3, 0, 0, 0, 0, 0, 0, 0);

        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_run("stop_beats_start", 3, 0, 0, 0, 0, 0, 0, 0);

        start_run(16'd3, 4'd3, 4'd3, 8'd0);
        check_run("abort_pre", 6, 'h21, 'h8, 'h8, 0, 'h3F, 0, -1);
        chk_vec("abort_wait", 6, 6'b000010);
        chk_idx("abort_wait", 6, 16'd1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_run("abort_post", 10, 0, 0, 0, 0, 0, 0, -1);
        start_run(16'd1, 4'd0, 4'd0, 8'd0);
        check_run("restart", 5, 'h1, 'h2, 'h2, 0, 'h7, 'h8, 1);

        start_run(16'd2, 4'd2, 4'd2, 8'd0);
        tick();
        tick();
        chk_vec("rst_pre", 2, 6'b011010);
        #2;
        grst = 1'b1;
        #1;
        chk_vec("rst_async", 0, 6'b000000);
        chk_idx("rst_async", 0, 16'd0);
        tick();
        chk_vec("rst_hold", 1, 6'b000000);
        grst = 1'b0;
        check_run("rst_after", 6, 0, 0, 0, 0, 0, 0, 0);
        start_run(16'd1, 4'd2, 4'd2, 8'd0);
        check_run("post_rst", 6, 'h1, 'h4, 'h4, 0, 'hF, 'h10, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
